keypad_encoder_4x4: RTL and testbench
=====================================

Name: keypad_encoder_4x4

Overview:
- Scans a 4x4 matrix keypad, debounces the press and release of a key, and encodes the active key into a 4-bit code.
- It is the input-side counterpart of the 4-bit-to-display decoding path: physical key in, binary code out.
- It delivers the code to the processor datapath through a valid/ack handshake.
- Rows are asynchronous board inputs; columns are driven outputs.

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven before its rows are sampled. Must be at least 4.
- DEBOUNCE_CNT, 20000: consecutive stable cycles required to accept a press or a release. Must be at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous.
- col_out  output  4  column drive, active-low one-hot; exactly one bit is 0 at all times.
- key_code  output  4  encoded key = 4*row + col, held stable between events.
- key_valid  output  1  new code available; level, held until acknowledged.
- key_ack  input  1  consumer acknowledge, sampled while key_valid=1.
- key_down  output  1  a debounced key is currently held.
- overrun  output  1  one-cycle pulse: a new key was accepted while key_valid was still 1.

Behaviour:
- Reset (async assert, sync release):
  - col_out=4'b1110 (column 0 driven); key_code=0; key_valid=0; key_down=0; overrun=0.
  - FSM=SCAN; all counters=0.
  - Reset mid-debounce or mid-press discards the pending key with no valid/overrun.
- row_in passes through a 2-flop synchronizer; all row references below mean the synchronized value (rs).
- Counter widths are $clog2 of the respective parameter; counters saturate and never wrap.
- FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
- SCAN:
  - Drive column c. The dwell counter counts 0..SCAN_DIV-1.
  - At the last dwell cycle, sample rs:
    - If any bit is 0, latch r = lowest-index low row and latch c, then go to DEBOUNCE (debounce counter=0).
    - Otherwise advance c (3 wraps to 0) and restart the dwell.
- DEBOUNCE:
  - Column c stays driven.
  - Each cycle rs[r] must be 0. If rs[r]=1, return to SCAN with the next column and no output change.
  - After DEBOUNCE_CNT consecutive cycles with rs[r]=0:
    - key_code <= {r[1:0], c[1:0]}; key_valid <= 1; key_down <= 1.
    - If key_valid was already 1 and key_ack is not 1 in that cycle, pulse overrun for one cycle. The new code overwrites the old.
    - Go to PRESSED.
- PRESSED: hold until rs[r]=1, then go to RELEASE (counter=0).
- RELEASE:
  - Requires DEBOUNCE_CNT consecutive cycles with rs[r]=1.
  - Any rs[r]=0 returns to PRESSED.
  - On completion: key_down <= 0, then SCAN with the next column.
- Other keys pressed while in DEBOUNCE, PRESSED or RELEASE are ignored (no rollover).
- Handshake:
  - key_ack=1 while key_valid=1 clears key_valid on the next edge.
  - key_ack while key_valid=0 is ignored.
  - A key accept and key_ack in the same cycle: the accept wins, key_valid stays 1 with the new code, and there is no overrun.
- Latency from a stable press to key_valid: at most 4*SCAN_DIV + 2 + DEBOUNCE_CNT + 1 cycles.
- key_code, key_valid, key_down and overrun are registered outputs with no combinational path from inputs.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state encoding (2-bit localparams: SCAN, DEBOUNCE, PRESSED, RELEASE).
  - COL_IDLE = 4'b1111 and column one-hot constants.
  - Key code constants KEY_0..KEY_F.
- One sub-module, sync_2ff, a parameterized-width 2-flop synchronizer, instantiated at width 4 for row_in.
- FSM, counters and handshake live in keypad_encoder_4x4.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
1. Reset, no keys -> col_out cycles 1110, 1101, 1011, 0111, 1110 with each value lasting 4 cycles; key_valid=0, key_down=0.
2. Hold row 2 low only while col_out=1101 (key r2,c1) for 60 cycles -> key_code=9, key_valid=1, key_down=1. Assert key_ack for 1 cycle -> key_valid=0 next cycle. Release -> key_down=0 after 8 high cycles; scanning resumes at col_out=1011.
3. Bounce: row 0 low for 3 cycles during DEBOUNCE, then high -> key_valid stays 0, key_code unchanged, scan advances to the next column.
4. Rows 1 and 3 both low on column 3 -> key_code=7 (row 1 wins).
5. Press key 5, no ack, release, then press key 10 -> key_code=10, key_valid=1, overrun pulses exactly 1 cycle.
6. Assert key_ack in the same cycle a new key is accepted -> key_valid remains 1, key_code=new value, overrun=0. Separately, assert rst during PRESSED -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad encoder: FSM states, column drive patterns,
// key codes and small combinational helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL_IDLE = 4'b1111;
    localparam logic [3:0] COL_0    = 4'b1110;
    localparam logic [3:0] COL_1    = 4'b1101;
    localparam logic [3:0] COL_2    = 4'b1011;
    localparam logic [3:0] COL_3    = 4'b0111;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] drive;
        case (c)
            2'd0:    drive = COL_0;
            2'd1:    drive = COL_1;
            2'd2:    drive = COL_2;
            2'd3:    drive = COL_3;
            default: drive = COL_IDLE;
        endcase
        return drive;
    endfunction

    // Lowest-index active-low row wins when several rows are pulled down.
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] r;
        if (!rows[0]) begin
            r = 2'd0;
        end else if (!rows[1]) begin
            r = 2'd1;
        end else if (!rows[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width two-flop synchronizer for asynchronous board inputs.
module sync_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q      <= RESET_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/keypad_encoder_4x4.sv
// 4x4 matrix keypad scanner with press/release debounce, 4-bit key encoding
// and a valid/ack handshake towards the processor datapath.
module keypad_encoder_4x4
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    localparam int DW  = $clog2(SCAN_DIV);
    localparam int DBW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  DWELL_ONE  = DW'(1);
    localparam logic [DBW-1:0] DEB_LAST   = DBW'(DEBOUNCE_CNT - 1);
    localparam logic [DBW-1:0] DEB_ONE    = DBW'(1);

    logic [3:0]     rs_s;
    logic [1:0]     col_next_s;
    logic           any_low_s;
    logic           row_high_s;
    logic           accept_s;

    state_t         state_r;
    logic [1:0]     col_r;
    logic [1:0]     row_r;
    logic [DW-1:0]  dwell_r;
    logic [DBW-1:0] deb_r;

    // Rows idle high (pull-ups), so the synchronizer resets to all ones.
    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'b1111)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_in),
        .q   (rs_s)
    );

    // Next column, row activity and the debounce-complete strobe.
    always_comb begin
        col_next_s = col_r + 2'd1;
        any_low_s  = ~&rs_s;
        row_high_s = rs_s[row_r];
        accept_s   = (state_r == DEBOUNCE) && !row_high_s && (deb_r == DEB_LAST);
    end

    // Scan/debounce FSM together with the output handshake registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= SCAN;
            col_r     <= 2'd0;
            row_r     <= 2'd0;
            dwell_r   <= '0;
            deb_r     <= '0;
            col_out   <= COL_0;
            key_code  <= KEY_0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            overrun <= 1'b0;
            // A fresh accept takes priority over a coincident acknowledge.
            if (accept_s) begin
                key_code  <= {row_r, col_r};
                key_valid <= 1'b1;
                key_down  <= 1'b1;
                overrun   <= key_valid && !key_ack;
            end else if (key_valid && key_ack) begin
                key_valid <= 1'b0;
            end

            case (state_r)
                SCAN: begin
                    if (dwell_r == DWELL_LAST) begin
                        dwell_r <= '0;
                        if (any_low_s) begin
                            row_r   <= low_row(rs_s);
                            deb_r   <= '0;
                            state_r <= DEBOUNCE;
                        end else begin
                            col_r   <= col_next_s;
                            col_out <= col_drive(col_next_s);
                        end
                    end else begin
                        dwell_r <= dwell_r + DWELL_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (row_high_s) begin
                        state_r <= SCAN;
                        dwell_r <= '0;
                        col_r   <= col_next_s;
                        col_out <= col_drive(col_next_s);
                    end else if (deb_r == DEB_LAST) begin
                        state_r <= PRESSED;
                    end else begin
                        deb_r <= deb_r + DEB_ONE;
                    end
                end
                PRESSED: begin
                    if (row_high_s) begin
                        deb_r   <= '0;
                        state_r <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!row_high_s) begin
                        state_r <= PRESSED;
                    end else if (deb_r == DEB_LAST) begin
                        key_down <= 1'b0;
                        state_r  <= SCAN;
                        dwell_r  <= '0;
                        col_r    <= col_next_s;
                        col_out  <= col_drive(col_next_s);
                    end else begin
                        deb_r <= deb_r + DEB_ONE;
                    end
                end
                default: begin
                    state_r <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_encoder_4x4.sv
// Directed self-checking bench for keypad_encoder_4x4 driving a modelled 4x4 key matrix.
module tb_keypad_encoder_4x4;

    logic        clk;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ack;
    logic        key_down;
    logic        overrun;

    logic [15:0] keys;
    int          tests;
    int          fails;
    int          ovr_cnt;

    keypad_encoder_4x4 #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ack   (key_ack),
        .key_down  (key_down),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a held key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Lands on the first negedge after the scan switches to the target column.
    task automatic wait_col(input string tag, input logic [3:0] target);
        int n;
        n = 0;
        while (col_out == target && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (col_out != target && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(tag, col_out, target);
    endtask

    task automatic wait_up(input string tag);
        int n;
        n = 0;
        while (key_down !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, key_down, 8'd0);
    endtask

    task automatic ack_pulse();
        key_ack = 1'b1;
        cyc(1);
        key_ack = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_col;
        tests   = 0;
        fails   = 0;
        ovr_cnt = 0;
        keys    = 16'h0000;
        key_ack = 1'b0;
        rst     = 1'b1;
        cyc(3);
        check("rst_col", col_out, 8'h0E);
        check("rst_code", key_code, 8'h0);
        check("rst_valid", key_valid, 8'd0);
        check("rst_down", key_down, 8'd0);
        check("rst_ovr", overrun, 8'd0);

        // 1: idle scan, each column held for 4 cycles
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            case ((i / 4) % 4)
                0:       exp_col = 4'b1110;
                1:       exp_col = 4'b1101;
                2:       exp_col = 4'b1011;
                default: exp_col = 4'b0111;
            endcase
            check("scan_col", col_out, exp_col);
            cyc(1);
        end
        check("idle_valid", key_valid, 8'd0);
        check("idle_down", key_down, 8'd0);

        // 2: key r2,c1 -> code 9, ack, release timing
        keys[9] = 1'b1;
        cyc(60);
        check("k9_code", key_code, 8'h9);
        check("k9_valid", key_valid, 8'd1);
        check("k9_down", key_down, 8'd1);
        check("k9_ovr", overrun, 8'd0);
        ack_pulse();
        check("k9_ack_valid", key_valid, 8'd0);
        check("k9_ack_code", key_code, 8'h9);
        keys = 16'h0000;
        cyc(10);
        check("k9_rel_held", key_down, 8'd1);
        cyc(1);
        check("k9_rel_down", key_down, 8'd0);
        check("k9_rel_col", col_out, 8'h0B);

        // 3: bounce on row 0 during debounce
        wait_col("bnc_sync", 4'b1110);
        keys[0] = 1'b1;
        cyc(5);
        keys[0] = 1'b0;
        cyc(4);
        check("bnc_col", col_out, 8'h0D);
        check("bnc_valid", key_valid, 8'd0);
        check("bnc_code", key_code, 8'h9);
        check("bnc_down", key_down, 8'd0);

        // 4: rows 1 and 3 on column 3 -> row 1 wins
        keys[7]  = 1'b1;
        keys[15] = 1'b1;
        cyc(60);
        check("multi_code", key_code, 8'h7);
        check("multi_valid", key_valid, 8'd1);
        ack_pulse();
        check("multi_ack", key_valid, 8'd0);
        keys = 16'h0000;
        wait_up("multi_up");

        // 5: key 5 unacknowledged, then key 10 -> single overrun pulse
        keys[5] = 1'b1;
        cyc(60);
        check("k5_code", key_code, 8'h5);
        check("k5_valid", key_valid, 8'd1);
        check("k5_ovr", overrun, 8'd0);
        keys = 16'h0000;
        wait_up("k5_up");
        check("k5_valid_kept", key_valid, 8'd1);
        keys[10] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (overrun === 1'b1) ovr_cnt++;
        end
        check("ovr_pulses", 8'(ovr_cnt), 8'd1);
        check("k10_code", key_code, 8'hA);
        check("k10_valid", key_valid, 8'd1);
        keys = 16'h0000;
        wait_up("k10_up");

        // 6: ack in the exact accept cycle of key 14 (r3,c2)
        wait_col("sim_sync", 4'b1011);
        keys[14] = 1'b1;
        cyc(11);
        check("sim_pre_code", key_code, 8'hA);
        check("sim_pre_valid", key_valid, 8'd1);
        key_ack = 1'b1;
        cyc(1);
        key_ack = 1'b0;
        check("sim_code", key_code, 8'hE);
        check("sim_valid", key_valid, 8'd1);
        check("sim_ovr", overrun, 8'd0);
        check("sim_down", key_down, 8'd1);
        cyc(1);
        check("sim_valid_hold", key_valid, 8'd1);

        // 6b: asynchronous reset while the key is held
        cyc(3);
        rst = 1'b1;
        #1;
        check("prst_col", col_out, 8'h0E);
        check("prst_code", key_code, 8'h0);
        check("prst_valid", key_valid, 8'd0);
        check("prst_down", key_down, 8'd0);
        check("prst_ovr", overrun, 8'd0);
        keys = 16'h0000;
        cyc(2);
        rst = 1'b0;
        cyc(30);
        check("post_valid", key_valid, 8'd0);
        check("post_down", key_down, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
